seg7_scan_driver: RTL and testbench
===================================

# seg7_scan_driver

Parametrised multiplexed driver for an N-digit common-anode 7-segment display. It latches a packed BCD word and per-digit decimal points on a load strobe, then time-multiplexes the digits. Each digit slot starts with a ghost-suppression guard interval. Leading-zero blanking is optional. The block sits between the datapath that produces BCD values and the board's segment/anode pins, and replaces per-digit static decoders.

## Interface
Parameters:
- NUM_DIGITS, 4: digits driven; legal range 1..8.
- REFRESH_DIV, 50000: clock cycles per digit slot; must be ≥ 2.
- GUARD, 2: cycles at the start of each slot with all anodes off; must satisfy 0 ≤ GUARD < REFRESH_DIV.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- bcd_in  input  4*NUM_DIGITS  packed BCD; bits [4i+3:4i] = digit i; digit 0 is least significant.
- dp_in  input  NUM_DIGITS  decimal point request per digit, 1 = lit.
- load  input  1  when high at a clock edge, bcd_in/dp_in are captured into the shadow registers.
- blank_lz  input  1  1 = suppress leading zeros (evaluated continuously, not latched).
- seg_out  output  7  segments {g,f,e,d,c,b,a}, active-low.
- dp_out  output  1  decimal point segment, active-low.
- an_out  output  NUM_DIGITS  anode enables, active-low; bit i = digit i.

## Operation
- Shadow registers hold digit values and dp bits. The display shows only the shadow contents. bcd_in changes without load have no effect.
- Prescaler cnt counts 0..REFRESH_DIV-1 and wraps to 0. The digit index idx advances when cnt = REFRESH_DIV-1; idx wraps NUM_DIGITS-1 → 0.
- Decode, active-low gfedcba: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000. Codes 10..15 give 1111111.
- Leading-zero blanking: with blank_lz=1, digit i>0 is blanked (seg 1111111, dp follows dp register) if it and every more-significant digit are 0. Digit 0 is never blanked, so all-zero displays "0".
- A blanked digit still asserts its anode. Only seg_out is forced off.
- Guard: while cnt < GUARD, the output state is an_out all 1, seg_out 1111111, dp_out 1.
- Otherwise: an_out has only bit idx low; seg_out = decode(shadow[idx]) with blanking applied; dp_out = ~dp_shadow[idx].

## Timing
- Outputs are registered. Values at edge k+1 are a function of cnt, idx and shadow state after edge k (1-cycle latency).
- Reset (rst_n low at an edge): cnt=0, idx=0, shadow digits 0, dp shadows 0, seg_out=1111111, dp_out=1, an_out all 1. Reset takes priority over load and the scan.
- First edge after rst_n returns high: cnt=0, idx=0. Outputs then show the guard state if GUARD>0.
- load at edge k: the shadow updates at k. If idx currently selects that digit outside guard, seg_out reflects the new value at edge k+1.
- load held high captures every cycle. load coinciding with a slot change is legal and has no interaction.
- Slot length is exactly REFRESH_DIV cycles. The full frame is NUM_DIGITS*REFRESH_DIV cycles. Anode active time per slot is REFRESH_DIV-GUARD cycles.
- NUM_DIGITS=1: idx is constant 0, but guard still repeats every REFRESH_DIV cycles.
- Reset mid-slot: the scan restarts at digit 0, cnt 0. Shadow contents are lost.

## Test plan
Use NUM_DIGITS=4, REFRESH_DIV=8, GUARD=2.
- Reset hold 3 cycles -> seg_out=1111111, dp_out=1, an_out=1111 during reset and on the first post-reset edge.
- load bcd_in=16'h1234, dp_in=4'b0100 -> per 8-cycle slot: 2 cycles an_out=1111, then 6 cycles an_out=1110 / seg 0011001, then 1101 / 0110000, then 1011 / 0100100 / dp_out=0, then 0111 / 1111001. The pattern repeats every 32 cycles.
- blank_lz=1, load 16'h0070 -> digits 3 and 2 give seg 1111111 with anode low; digit 1 gives 1111000; digit 0 gives 1000000. With load 16'h0000: only digit 0 shows 1000000.
- load 16'h00AF with blank_lz=0 -> digits 1 and 0 give 1111111; digits 3 and 2 give 1000000.
- Change bcd_in to 16'h9999 with load=0 for a full frame -> outputs unchanged. Then pulse load -> the next active slot shows 0010000.
- Assert rst_n=0 for 1 cycle during digit 2's active window -> the next edge shows reset outputs. The scan resumes with a digit 0 guard, shadows are 0, and digit 0 shows 1000000.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// Multiplexed N-digit common-anode 7-segment driver: latches a BCD word and dp bits on load and
// scans them out with a per-slot all-off guard interval and optional leading-zero blanking.
module seg7_scan_driver #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int GUARD       = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
    input  logic                    blank_lz,
    output logic [6:0]              seg_out,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   an_out
);
    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [6:0] SEG_OFF = 7'b1111111;

    logic [CNT_W-1:0]      cnt;
    logic [IDX_W-1:0]      idx;
    logic [3:0]            digit_q [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] dp_q;

    logic [NUM_DIGITS-1:0] blanked;
    logic                  in_guard;
    logic [6:0]            seg_next;
    logic                  dp_next;
    logic [NUM_DIGITS-1:0] an_next;

    // Active-low gfedcba; non-BCD codes show nothing.
    function automatic logic [6:0] decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_OFF;
        endcase
        return s;
    endfunction

    // A digit is a leading zero when it and everything above it are zero; digit 0 always shows.
    always_comb begin
        logic zero_above;
        zero_above = 1'b1;
        blanked    = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_above = zero_above && (digit_q[i] == 4'd0);
            blanked[i] = blank_lz && zero_above && (i != 0);
        end
    end

    assign in_guard = (int'(cnt) < GUARD);

    always_comb begin
        seg_next = SEG_OFF;
        dp_next  = 1'b1;
        an_next  = '1;
        if (!in_guard) begin
            an_next  = ~(NUM_DIGITS'(1) << idx);
            seg_next = blanked[idx] ? SEG_OFF : decode(digit_q[idx]);
            dp_next  = ~dp_q[idx];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt     <= '0;
            idx     <= '0;
            digit_q <= '{default: 4'd0};
            dp_q    <= '0;
            seg_out <= SEG_OFF;
            dp_out  <= 1'b1;
            an_out  <= '1;
        end else begin
            seg_out <= seg_next;
            dp_out  <= dp_next;
            an_out  <= an_next;

            if (load) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    digit_q[i] <= bcd_in[4*i +: 4];
                end
                dp_q <= dp_in;
            end

            if (cnt == CNT_LAST) begin
                cnt <= '0;
                idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: a cycle-count reference model queues the expected
// pin state for every clock edge and a negedge monitor compares the DUT against it.
module tb_seg7_scan_driver;
    localparam int ND = 4;
    localparam int RD = 8;
    localparam int GD = 2;

    localparam logic [6:0] SEG_TBL [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    typedef struct packed {
        logic [6:0] seg;
        logic       dp;
        logic [3:0] an;
    } out_t;

    localparam out_t OFF_OUT = '{seg: 7'b1111111, dp: 1'b1, an: 4'b1111};

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [15:0]   bcd_in = '0;
    logic [ND-1:0] dp_in = '0;
    logic          load = 1'b0;
    logic          blank_lz = 1'b0;
    logic [6:0]    seg_out;
    logic          dp_out;
    logic [ND-1:0] an_out;

    int checks = 0;
    int errors = 0;

    out_t          exp_q[$];
    logic [3:0]    m_dig [ND];
    logic [ND-1:0] m_dp = '0;
    int            m_n = 0;

    seg7_scan_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .GUARD(GD)) dut (
        .clk(clk), .rst_n(rst_n), .bcd_in(bcd_in), .dp_in(dp_in), .load(load),
        .blank_lz(blank_lz), .seg_out(seg_out), .dp_out(dp_out), .an_out(an_out)
    );

    always #5 clk = ~clk;

    initial begin
        for (int j = 0; j < ND; j++) m_dig[j] = 4'd0;
    end

    // Pin state implied by the number of scan cycles elapsed since reset.
    function automatic out_t model_out();
        out_t o;
        int   pos;
        int   d;
        bit   lead;
        o   = OFF_OUT;
        pos = m_n % RD;
        d   = (m_n / RD) % ND;
        if (pos >= GD) begin
            o.an    = 4'b1111;
            o.an[d] = 1'b0;
            lead = 1'b1;
            for (int j = d; j < ND; j++) if (m_dig[j] != 4'd0) lead = 1'b0;
            if (blank_lz && d > 0 && lead) o.seg = 7'b1111111;
            else if (m_dig[d] < 4'd10)     o.seg = SEG_TBL[m_dig[d]];
            else                           o.seg = 7'b1111111;
            o.dp = ~m_dp[d];
        end
        return o;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            exp_q.push_back(OFF_OUT);
            m_n  = 0;
            m_dp = '0;
            for (int j = 0; j < ND; j++) m_dig[j] = 4'd0;
        end else begin
            exp_q.push_back(model_out());
            if (load) begin
                for (int j = 0; j < ND; j++) m_dig[j] = bcd_in[4*j +: 4];
                m_dp = dp_in;
            end
            m_n++;
        end
    end

    always @(negedge clk) begin
        out_t e;
        out_t got;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            got = '{seg: seg_out, dp: dp_out, an: an_out};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL scan t=%0t got seg=%b dp=%b an=%b expected seg=%b dp=%b an=%b",
                         $time, got.seg, got.dp, got.an, e.seg, e.dp, e.an);
            end
        end
    end

    task automatic step(input int k);
        repeat (k) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic load_word(input logic [15:0] w, input logic [ND-1:0] d);
        bcd_in = w;
        dp_in  = d;
        load   = 1'b1;
        step(1);
        load   = 1'b0;
    endtask

    initial begin
        int guard_cnt;
        rst_n = 1'b0;
        step(3);
        rst_n = 1'b1;

        load_word(16'h1234, 4'b0100);
        step(2 * ND * RD);

        blank_lz = 1'b1;
        load_word(16'h0070, 4'b0000);
        step(ND * RD);
        load_word(16'h0000, 4'b0000);
        step(ND * RD);

        blank_lz = 1'b0;
        load_word(16'h00AF, 4'b0000);
        step(ND * RD);

        bcd_in = 16'h9999;
        step(ND * RD);
        load = 1'b1;
        step(1);
        load = 1'b0;
        step(ND * RD);

        // Reset while digit 2 is lit.
        guard_cnt = 0;
        while (!(((m_n / RD) % ND) == 2 && (m_n % RD) >= GD + 1) && guard_cnt < 4 * ND * RD) begin
            step(1);
            guard_cnt++;
        end
        checks++;
        if (guard_cnt >= 4 * ND * RD) begin
            errors++;
            $display("FAIL digit2_window_wait waited=%0d limit=%0d", guard_cnt, 4 * ND * RD);
        end
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        step(ND * RD + 8);

        for (int c = 0; c < 2000; c++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 49) == 0) blank_lz = ~blank_lz;
            bcd_in = 16'($urandom) >> (4 * $urandom_range(0, 4));
            dp_in  = 4'($urandom);
            load   = ($urandom_range(0, 7) == 0);
            step(1);
        end
        load  = 1'b0;
        rst_n = 1'b1;
        step(1);
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
